// File: rtl/e_mdu_param.sv
// e_mdu_param: E-stage multiply/divide unit owning HI/LO.
// Arithmetic ops latch their operands and count down a fixed latency.
// HI/LO are written only at the final count edge, so they never show partial results.
module e_mdu_param #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       MDUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);
   localparam int unsigned W2   = 2 * WIDTH;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [2:0]       op_q, op_d;

   logic [W2-1:0]           prod_c;
   logic signed [WIDTH-1:0] sa_c, sb_c, sq_c, sr_c;
   logic [WIDTH-1:0]        uq_c, ur_c;
   logic                    b_zero_c, ovf_c;
   logic [WIDTH-1:0]        res_hi_c, res_lo_c;

   assign busy = (cnt_q != '0);
   assign HI   = hi_q;
   assign LO   = lo_q;

   // Result of the latched operation, evaluated from the held operands
   always_comb begin
      if (op_q == OP_MULT)
         prod_c = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
      else
         prod_c = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      sa_c     = a_q;
      sb_c     = b_q;
      sq_c     = sa_c / sb_c;
      sr_c     = sa_c % sb_c;
      uq_c     = a_q / b_q;
      ur_c     = a_q % b_q;
      b_zero_c = (b_q == '0);
      // most-negative / -1 cannot be represented; defined as quotient=A, remainder=0
      ovf_c    = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
      res_hi_c = hi_q;
      res_lo_c = lo_q;
      case (op_q)
         OP_MULT, OP_MULTU: {res_hi_c, res_lo_c} = prod_c;
         OP_DIV: begin
            if (b_zero_c) begin
               res_hi_c = a_q;
               res_lo_c = '1;
            end else if (ovf_c) begin
               res_hi_c = '0;
               res_lo_c = a_q;
            end else begin
               res_hi_c = sr_c;
               res_lo_c = sq_c;
            end
         end
         OP_DIVU: begin
            if (b_zero_c) begin
               res_hi_c = a_q;
               res_lo_c = '1;
            end else begin
               res_hi_c = ur_c;
               res_lo_c = uq_c;
            end
         end
         default: ;
      endcase
   end

   // Next state: cancel wins, then countdown/commit, then accept of a new request
   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (cancel) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            hi_d = res_hi_c;
            lo_d = res_lo_c;
         end
      end else if (start) begin
         case (MDUOp)
            OP_MULT, OP_MULTU: begin
               a_d   = A;
               b_d   = B;
               op_d  = MDUOp;
               cnt_d = CW'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
               a_d   = A;
               b_d   = B;
               op_d  = MDUOp;
               cnt_d = CW'(DIV_CYCLES);
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
         endcase
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         op_q  <= op_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

endmodule

// File: tb/tb_e_mdu_param.sv
// tb_e_mdu_param: scoreboard bench for e_mdu_param with a behavioural HI/LO model.
module tb_e_mdu_param;

   localparam int unsigned W  = 32;
   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic         clk;
   logic         reset;
   logic         start;
   logic [2:0]   MDUOp;
   logic [W-1:0] A, B;
   logic         cancel;
   logic         busy;
   logic [W-1:0] HI, LO;

   e_mdu_param #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
      .cancel(cancel), .busy(busy), .HI(HI), .LO(LO)
   );

   typedef struct {
      int          len;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result: {HI, LO} from plain integer arithmetic
   function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned up;
      logic [31:0]     uq, ur;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         3'd1: return 64'(sa * sb);
         3'd2: begin
            up = {32'h0, a} * {32'h0, b};
            return up;
         end
         3'd3: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
            q = sa / sb;
            r = sa - q * sb;
            return {r[31:0], q[31:0]};
         end
         3'd4: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            uq = a / b;
            ur = a - uq * b;
            return {ur, uq};
         end
         default: return {hi_m, lo_m};
      endcase
   endfunction

   // Monitor: each busy window end pops one expected {length, HI, LO}
   initial begin
      logic        prev_busy;
      int          blen;
      logic [31:0] hi_at, lo_at;
      logic        stable;
      exp_t        e;
      prev_busy = 1'b0;
      blen      = 0;
      hi_at     = '0;
      lo_at     = '0;
      stable    = 1'b1;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            if (!prev_busy) begin
               blen   = 0;
               hi_at  = HI;
               lo_at  = LO;
               stable = 1'b1;
            end
            blen++;
            if (HI !== hi_at || LO !== lo_at) stable = 1'b0;
         end else if (prev_busy) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_busy_window", 64'(blen), 64'(0));
            end else begin
               e = sb_q.pop_front();
               chk("busy_len", 64'(blen), 64'(e.len));
               chk("hilo_stable_while_busy", 64'(stable), 64'(1));
               chk("commit_hi", 64'(HI), 64'(e.hi));
               chk("commit_lo", 64'(LO), 64'(e.lo));
            end
         end
         prev_busy = (busy === 1'b1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      MDUOp = op;
      A     = a;
      B     = b;
      step();
      start = 1'b0;
      MDUOp = 3'd0;
   endtask

   // Arithmetic op; cancel_at=k>0 asserts cancel during the k-th busy cycle
   task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int cancel_at);
      logic [63:0] r;
      int          n;
      exp_t        e;
      r = ref_calc(op, a, b);
      n = (op <= 3'd2) ? int'(MC) : int'(DC);
      issue(op, a, b);
      if (cancel_at == 0) begin
         e.len = n;
         e.hi  = r[63:32];
         e.lo  = r[31:0];
         sb_q.push_back(e);
         hi_m = r[63:32];
         lo_m = r[31:0];
         repeat (n) step();
      end else begin
         e.len = cancel_at;
         e.hi  = hi_m;
         e.lo  = lo_m;
         sb_q.push_back(e);
         repeat (cancel_at - 1) step();
         cancel = 1'b1;
         step();
         cancel = 1'b0;
         chk("busy_after_cancel", 64'(busy), 64'(0));
      end
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] a);
      issue(op, a, 32'h0);
      if (op == 3'd5) hi_m = a;
      if (op == 3'd6) lo_m = a;
      chk("mt_hi", 64'(HI), 64'(hi_m));
      chk("mt_lo", 64'(LO), 64'(lo_m));
      chk("mt_busy", 64'(busy), 64'(0));
   endtask

   function automatic logic [31:0] pick(input int sel);
      case (sel)
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'(1);
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          k;
      reset  = 1'b0;
      start  = 1'b1;
      MDUOp  = 3'd5;
      A      = 32'h1234;
      B      = 32'h0;
      cancel = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("reset_hi", 64'(HI), 64'(0));
         chk("reset_lo", 64'(LO), 64'(0));
         chk("reset_busy", 64'(busy), 64'(0));
      end
      step();
      reset = 1'b1;
      start = 1'b0;
      MDUOp = 3'd0;
      repeat (2) step();
      chk("idle_hi", 64'(HI), 64'(0));
      chk("idle_lo", 64'(LO), 64'(0));

      run_arith(3'd1, 32'hFFFF_FFFD, 32'd5, 0);
      chk("mult_neg_hi", 64'(HI), 64'hFFFF_FFFF);
      chk("mult_neg_lo", 64'(LO), 64'hFFFF_FFF1);
      run_arith(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
      chk("multu_hi", 64'(HI), 64'h1);
      chk("multu_lo", 64'(LO), 64'hFFFF_FFFE);
      run_arith(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
      chk("div_neg_lo", 64'(LO), 64'hFFFF_FFFD);
      chk("div_neg_hi", 64'(HI), 64'hFFFF_FFFF);
      run_arith(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("div_ovf_lo", 64'(LO), 64'h8000_0000);
      chk("div_ovf_hi", 64'(HI), 64'h0);
      run_arith(3'd4, 32'h55, 32'h0, 0);
      chk("divu_zero_lo", 64'(LO), 64'hFFFF_FFFF);
      chk("divu_zero_hi", 64'(HI), 64'h55);

      // mthi request in busy cycle 3 must be ignored
      begin
         exp_t e;
         e.len = int'(DC);
         e.hi  = 32'd2;
         e.lo  = 32'd14;
         sb_q.push_back(e);
         issue(3'd3, 32'd100, 32'd7);
         hi_m = 32'd2;
         lo_m = 32'd14;
         repeat (2) step();
         start = 1'b1;
         MDUOp = 3'd5;
         A     = 32'hAAAA;
         step();
         start = 1'b0;
         MDUOp = 3'd0;
         repeat (DC - 3) step();
         chk("ignore_busy_hi", 64'(HI), 64'd2);
      end

      mt(3'd5, 32'h11);
      mt(3'd6, 32'h22);
      run_arith(3'd1, 32'd7, 32'd9, 4);
      chk("cancel_hi", 64'(HI), 64'h11);
      chk("cancel_lo", 64'(LO), 64'h22);
      run_arith(3'd1, 32'd3, 32'd4, 0);
      chk("after_cancel_lo", 64'(LO), 64'd12);
      chk("after_cancel_hi", 64'(HI), 64'd0);

      run_arith(3'd1, 32'd2, 32'd3, 0);
      mt(3'd6, 32'h99);
      chk("b2b_lo", 64'(LO), 64'h99);
      chk("b2b_hi", 64'(HI), 64'h0);

      // cancel on the final count edge discards the commit
      run_arith(3'd4, 32'd1000, 32'd3, int'(DC));
      // cancel suppresses an idle mtlo
      start  = 1'b1;
      MDUOp  = 3'd6;
      A      = 32'hDEAD;
      cancel = 1'b1;
      step();
      start  = 1'b0;
      cancel = 1'b0;
      MDUOp  = 3'd0;
      chk("cancel_mt_lo", 64'(LO), 64'(lo_m));

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick($urandom_range(0, 9));
         b  = pick($urandom_range(0, 9));
         if (op >= 3'd1 && op <= 3'd4) begin
            k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, (op <= 3'd2) ? MC : DC)) : 0;
            run_arith(op, a, b, k);
         end else if (op == 3'd5 || op == 3'd6) begin
            mt(op, a);
         end else begin
            issue(op, a, b);
            chk("noop_hi", 64'(HI), 64'(hi_m));
            chk("noop_lo", 64'(LO), 64'(lo_m));
         end
      end

      repeat (3) step();
      chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/e_mdu_param.md
Name: e_mdu_param

Overview:
Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined core. It owns the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo. It exposes a `busy` flag so the hazard unit can stall instructions that touch HI/LO while an operation is in flight. Operand width and per-operation latency are configurable; it also supports aborting an in-flight operation via `cancel`.

Parameters:
WIDTH, 32, operand and HI/LO width in bits
MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO commit (>=1)
DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO commit (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
start  input  1  op request qualifier from E stage; high for one cycle per instruction
MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
A  input  WIDTH  forwarded rs value
B  input  WIDTH  forwarded rt value
cancel  input  1  abort an in-flight op and suppress any request this cycle
busy  output  1  an arithmetic op is in flight
HI  output  WIDTH  committed HI register
LO  output  WIDTH  committed LO register

Behaviour:
- Reset (reset==0 at an edge) has top priority: counter=0, busy=0, HI=0, LO=0, latched operands and op cleared.
- busy is a pure decode of the internal countdown counter: busy = (cnt != 0). busy=0 out of reset.
- Accept rule: an op is accepted at an edge when start=1, busy=0, cancel=0 and MDUOp is in 1..6.
- While busy=1, start is ignored for every MDUOp, including mthi/mtlo; the hazard unit guarantees no such request is issued.
- mult/multu/div/divu:
  - On accept, latch A, B and the op, and load cnt with MULT_CYCLES or DIV_CYCLES.
  - cnt decrements by 1 at each later edge.
  - At the edge where cnt goes 1->0, HI and LO are written with the result.
  - Net effect: busy is high for exactly N cycles after the accepting edge. The new HI/LO are visible in the first cycle that busy=0.
- mthi/mtlo: on accept, HI<=A (mthi) or LO<=A (mtlo) at the same edge. No busy cycles.
- mult: signed 2*WIDTH product, {HI,LO}=A*B.
- multu: unsigned 2*WIDTH product, {HI,LO}=A*B.
- div: signed, truncates toward zero. LO=quotient, HI=remainder; the remainder takes the sign of the dividend.
- divu: unsigned. LO=quotient, HI=remainder.
- Divide by zero (B==0):
  - LO = all ones.
  - HI = A, for both div and divu.
- Signed overflow (A = most-negative value, B = -1, div only): LO=A, HI=0.
- Result latency is fixed and independent of operand values, including the zero and overflow cases.
- cancel=1 at an edge:
  - cnt is forced to 0.
  - The pending result is discarded; HI and LO keep their prior values.
  - Any accept in the same cycle, including mthi/mtlo, is suppressed.
- cancel during the cnt 1->0 edge also discards the commit.
- Back-to-back ops: a new op may be accepted in the first cycle busy=0. If the new op is mthi/mtlo, it writes at that edge, after the previous commit has already landed.
- Microarchitecture (array or iterative shift-add/subtract) is free, provided cycle-level visibility matches the above. HI and LO must never show partial results.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1, MDUOp=5, A=0x1234 -> HI=LO=0, busy=0 throughout; after release, idle cycles leave HI and LO unchanged.
- mult A=0xFFFFFFFD (-3), B=5 with defaults -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. divu A=0x55, B=0 -> LO=0xFFFFFFFF, HI=0x55.
- Ignore while busy: start a div, then on cycle 3 assert start with MDUOp=5, A=0xAAAA -> the request is ignored; HI ends as the div remainder, not 0xAAAA; busy still drops after exactly 10 cycles.
- Cancel: set HI=0x11 and LO=0x22 via mthi/mtlo; start mult 7*9; assert cancel on cycle 4 -> busy=0 on the next cycle; HI=0x11 and LO=0x22 are unchanged; a mult 3*4 accepted next gives LO=12, HI=0.
- Back-to-back: mult 2*3 followed by mtlo A=0x99 in the first non-busy cycle -> LO=6 for one cycle, then LO=0x99; HI=0 throughout.
